m68k_bus_engine: RTL and testbench
==================================

Name: m68k_bus_engine

Overview:
Parametrised successor to the PiStorm-Atari 68000 bus state machine. Requests from the Pi register interface (address, FC, RW, size, write data) are queued in a request FIFO. Each request runs as one or two native 68000 bus cycles, sampled on the 200 MHz Pi clock against the synchronised M68K_CLK. New behaviour: request queue with posted writes, byte/word/long transfers (a long splits into two word cycles), DTACK timeout generating a synthetic bus error, and a parametrised E clock with a 6800 VPA/VMA cycle.

Parameters:
SYNC_STAGES, 3, flops in the M68K_CLK synchroniser (≥2)
FIFO_DEPTH, 4, request queue entries (power of 2, ≥2)
TIMEOUT_CYCLES, 256, M68K_CLK falling edges in WAIT before synthetic BERR
E_DIV, 10, M68K_CLK periods per E period
E_HIGH_START, 6, e_cnt value at which E goes high (E high for counts E_HIGH_START..E_DIV-1)

Ports:
PI_CLK  in  1  sole clock (200 MHz)
SYS_RESET_n  in  1  synchronous active-low reset
ABORT  in  1  status-register state-machine reset: flush queue, drop current cycle
REQ_VALID  in  1  request strobe
REQ_READY  out  1  queue not full
REQ_ADDR  in  24  byte address
REQ_RW  in  1  1=read
REQ_SIZE  in  2  0=byte, 1=word, 2=long (3 is reserved and treated as misaligned)
REQ_FC  in  3  function code
REQ_WDATA  in  32  write data (right-justified)
RSP_VALID  out  1  one-cycle pulse per completed request
RSP_BERR  out  1  error flag, valid with RSP_VALID
RSP_RDATA  out  32  read data, valid with RSP_VALID
TXN_BUSY  out  1  queue non-empty or FSM not IDLE
M68K_CLK  in  1  asynchronous 8 MHz bus clock
M68K_A  out  23  A[23:1]
M68K_D_OUT  out  16  write data
M68K_D_IN  in  16  read data
M68K_D_OE  out  1  data driver enable
BUS_OE  out  1  address/strobe driver enable; 1 only while synced BGACK_n=1
M68K_FC  out  3; M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n  out  1 each
M68K_E  out  1  E clock
M68K_DTACK_n, M68K_BERR_n, M68K_VPA_n, M68K_BGACK_n  in  1 each, asynchronous

Behaviour:
- Reset (SYS_RESET_n=0 at a PI_CLK edge): FSM=IDLE; queue empty; AS_n/UDS_n/LDS_n/VMA_n=1; RW=1; FC=3'b111; D_OE=0; E=0; e_cnt=0; RSP_VALID=0; RSP_BERR=0; RSP_RDATA=0; REQ_READY=1 on the next cycle.
- The M68K_CLK synchroniser is SYS_RESET_n-reset to 0. rise/fall = edge detect on the last two stages. DTACK_n, BERR_n, VPA_n and BGACK_n use 2-flop synchronisers, reset to 1.
- E clock: e_cnt advances on each fall and wraps E_DIV-1→0. E=1 iff e_cnt≥E_HIGH_START.
- Queue: a push happens when REQ_VALID&&REQ_READY. A simultaneous push and pop is allowed when the queue is full. A misaligned request (size≠byte with A0=1, or size=3) is popped without any bus cycle and gives RSP_VALID with RSP_BERR=1 one cycle after the pop.
- FSM:
  - IDLE: if the queue is non-empty and synced BGACK_n=1 → pop and go to S_ADDR.
  - S_ADDR: on the next rise, drive A, FC, RW and D_OUT; D_OE=!RW → S_STRB.
  - S_STRB: on fall, AS_n=0 and UDS_n/LDS_n per lane → WAIT; clear the timeout counter.
  - WAIT: evaluated on each fall.
    - DTACK_n=0 or BERR_n=0 → TERM.
    - VPA_n=0 and e_cnt==2 → VMA_n=0.
    - VMA_n=0 and e_cnt==8 → TERM.
    - Timeout counter reaches TIMEOUT_CYCLES → TERM with the error flag set.
  - TERM: on rise, latch M68K_D_IN for reads → S_END.
  - S_END: on fall, AS_n/UDS_n/LDS_n/VMA_n=1 and D_OE=0.
    - If first half of a long and no error → S_ADDR with A+1 (byte address +2).
    - Otherwise pulse RSP_VALID → IDLE.
- Lanes:
  - Byte: A0=0 selects UDS, A0=1 selects LDS. Write byte is replicated on both lanes. Read returns the selected lane in RDATA[7:0], with upper bits 0.
  - Word: both strobes; data in [15:0].
  - Long: high word first ([31:16]), then low word.
- Error: RSP_BERR = BERR_n sampled low, or timeout, or misalignment. A BERR in the first half of a long aborts the second half.
- ABORT (or SYS_RESET_n) mid-cycle: strobes negated and D_OE=0 on the next PI_CLK edge; queue flushed; no RSP_VALID is issued.
- BGACK_n low while in IDLE blocks starts and forces BUS_OE=0. BGACK_n is ignored during an active cycle, because legal arbitration cannot grant mid-cycle.

Decomposition:
- Package m68k_bus_pkg holds:
  - FSM state encoding (IDLE, S_ADDR, S_STRB, WAIT, TERM, S_END)
  - SIZE_BYTE/WORD/LONG constants
  - E_VMA_ASSERT=2 and E_VMA_TERM=8
  - request struct {addr, rw, size, fc, wdata}
- One sub-module: m68k_req_fifo, a synchronous FIFO with full/empty flags and a flush input.

Test Plan:
- Word read 0xFF8800, DTACK at the 2nd fall in WAIT → UDS_n=LDS_n=0, RSP_VALID with RDATA=0x0000_ABCD (bus word 0xABCD), BERR=0.
- Long write 0x000400 data 0x1234_5678 → two cycles: A=0x000200 D=0x1234, then A=0x000201 D=0x5678; one RSP_VALID.
- Byte read 0xFFFA01 via VPA → VMA_n falls at e_cnt=2 and the cycle ends at e_cnt=8; LDS only; RDATA=0x0000_00xx.
- No DTACK, TIMEOUT_CYCLES=16 → RSP_BERR=1 after 16 falls, strobes negated.
- Push 5 writes with FIFO_DEPTH=4 and no pops → REQ_READY=0 after the 4th; assert ABORT mid-cycle → strobes high next cycle, TXN_BUSY=0, no response.
- Word request at odd address 0x000003 → no AS_n assertion, RSP_BERR=1; BGACK_n low → no cycle starts and BUS_OE=0.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared state encoding, size codes and request record for the 68000 bus engine
package m68k_bus_pkg;
  typedef enum logic [2:0] {IDLE, S_ADDR, S_STRB, WAIT, TERM, S_END} state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_WORD = 2'd1;
  localparam logic [1:0] SIZE_LONG = 2'd2;
  localparam int E_VMA_ASSERT = 2;
  localparam int E_VMA_TERM = 8;
  typedef struct packed {
    logic [23:0] addr;
    logic        rw;
    logic [1:0]  size;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;
  function automatic logic misaligned(input req_t r);
    return r.size == 2'd3 || (r.size != SIZE_BYTE && r.addr[0]);
  endfunction
endpackage

// File: rtl/m68k_req_fifo.sv
// m68k_req_fifo: request queue with full/empty flags and a flush input
module m68k_req_fifo
  import m68k_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  req_t mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  always_comb begin
    wp_d = flush ? '0 : wp_q + {{AW{1'b0}}, push};
    rp_d = flush ? '0 : rp_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
    if (push) mem_q[wp_q[AW-1:0]] <= din;
  end
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = wp_q == rp_q;
  assign dout  = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/m68k_bus_engine.sv
// m68k_bus_engine: queued 68000 bus cycles with long splitting, DTACK timeout and a 6800 VPA/VMA cycle
module m68k_bus_engine
  import m68k_bus_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int E_DIV          = 10,
  parameter int E_HIGH_START   = 6
) (
  input  logic        PI_CLK,
  input  logic        SYS_RESET_n,
  input  logic        ABORT,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [23:0] REQ_ADDR,
  input  logic        REQ_RW,
  input  logic [1:0]  REQ_SIZE,
  input  logic [2:0]  REQ_FC,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic        RSP_BERR,
  output logic [31:0] RSP_RDATA,
  output logic        TXN_BUSY,
  input  logic        M68K_CLK,
  output logic [22:0] M68K_A,
  output logic [15:0] M68K_D_OUT,
  input  logic [15:0] M68K_D_IN,
  output logic        M68K_D_OE,
  output logic        BUS_OE,
  output logic [2:0]  M68K_FC,
  output logic        M68K_AS_n,
  output logic        M68K_UDS_n,
  output logic        M68K_LDS_n,
  output logic        M68K_RW,
  output logic        M68K_VMA_n,
  output logic        M68K_E,
  input  logic        M68K_DTACK_n,
  input  logic        M68K_BERR_n,
  input  logic        M68K_VPA_n,
  input  logic        M68K_BGACK_n
);
  localparam int EW = $clog2(E_DIV);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] mclk_q, mclk_d;
  logic [1:0][3:0] async_q, async_d;
  state_t state_q, state_d;
  req_t cur_q, cur_d, fifo_dout;
  logic second_q, second_d, err_q, err_d, doe_q, doe_d, rw_q, rw_d;
  logic as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d, vma_n_q, vma_n_d;
  logic rsp_valid_q, rsp_valid_d, rsp_berr_q, rsp_berr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [EW-1:0] e_cnt_q, e_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [22:0] a_q, a_d;
  logic [2:0] fc_q, fc_d;
  logic [15:0] dout_q, dout_d;
  logic rise, fall, dtack_s, berr_s, vpa_s, bgack_s, full, empty, pop, push, is_byte, is_long;
  assign rise    = mclk_q[SYNC_STAGES-2] & ~mclk_q[SYNC_STAGES-1];
  assign fall    = ~mclk_q[SYNC_STAGES-2] & mclk_q[SYNC_STAGES-1];
  assign {dtack_s, berr_s, vpa_s, bgack_s} = async_q[1];
  assign is_byte = cur_q.size == SIZE_BYTE;
  assign is_long = cur_q.size == SIZE_LONG;
  assign push    = REQ_VALID && REQ_READY;
  m68k_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(PI_CLK), .rst_n(SYS_RESET_n), .flush(ABORT), .push(push), .pop(pop),
    .din('{REQ_ADDR, REQ_RW, REQ_SIZE, REQ_FC, REQ_WDATA}), .dout(fifo_dout), .full(full), .empty(empty)
  );
  always_comb begin
    mclk_d = {mclk_q[SYNC_STAGES-2:0], M68K_CLK};
    async_d = {async_q[0], {M68K_DTACK_n, M68K_BERR_n, M68K_VPA_n, M68K_BGACK_n}};
    e_cnt_d = fall ? (e_cnt_q == EW'(E_DIV - 1) ? '0 : e_cnt_q + EW'(1)) : e_cnt_q;
    state_d = state_q;
    cur_d = cur_q;
    second_d = second_q;
    err_d = err_q;
    tmo_d = tmo_q;
    rdata_d = rdata_q;
    a_d = a_q;
    fc_d = fc_q;
    rw_d = rw_q;
    dout_d = dout_q;
    doe_d = doe_q;
    as_n_d = as_n_q;
    uds_n_d = uds_n_q;
    lds_n_d = lds_n_q;
    vma_n_d = vma_n_q;
    rsp_valid_d = 1'b0;
    rsp_berr_d = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty && bgack_s) begin
        pop = 1'b1;
        cur_d = fifo_dout;
        second_d = 1'b0;
        err_d = 1'b0;
        rdata_d = '0;
        rsp_valid_d = misaligned(fifo_dout);
        rsp_berr_d = misaligned(fifo_dout);
        state_d = misaligned(fifo_dout) ? IDLE : S_ADDR;
      end
      S_ADDR: if (rise) begin
        a_d = cur_q.addr[23:1] + {22'b0, second_q};
        fc_d = cur_q.fc;
        rw_d = cur_q.rw;
        doe_d = !cur_q.rw;
        dout_d = is_byte ? {2{cur_q.wdata[7:0]}} : (is_long && !second_q) ? cur_q.wdata[31:16] : cur_q.wdata[15:0];
        state_d = S_STRB;
      end
      S_STRB: if (fall) begin
        as_n_d = 1'b0;
        uds_n_d = is_byte && cur_q.addr[0];
        lds_n_d = is_byte && !cur_q.addr[0];
        tmo_d = '0;
        state_d = WAIT;
      end
      WAIT: if (fall) begin
        // a VMA cycle is paced by E and always ends, so it does not run the timeout
        tmo_d = tmo_q + {{(TW-1){1'b0}}, vma_n_q};
        err_d = err_q || !berr_s || tmo_d == TW'(TIMEOUT_CYCLES);
        vma_n_d = vma_n_q && !(!vpa_s && e_cnt_q == EW'(E_VMA_ASSERT));
        state_d = (!dtack_s || !berr_s || tmo_d == TW'(TIMEOUT_CYCLES) || (!vma_n_q && e_cnt_q == EW'(E_VMA_TERM))) ? TERM : WAIT;
      end
      TERM: if (rise) begin
        rdata_d = !cur_q.rw ? rdata_q
                : is_byte ? {24'b0, cur_q.addr[0] ? M68K_D_IN[7:0] : M68K_D_IN[15:8]}
                : (is_long && !second_q) ? {M68K_D_IN, rdata_q[15:0]} : {rdata_q[31:16], M68K_D_IN};
        state_d = S_END;
      end
      S_END: if (fall) begin
        {as_n_d, uds_n_d, lds_n_d, vma_n_d, doe_d} = 5'b11110;
        second_d = 1'b1;
        rsp_valid_d = !(is_long && !second_q && !err_q);
        rsp_berr_d = err_q;
        state_d = (is_long && !second_q && !err_q) ? S_ADDR : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ABORT) begin
      {as_n_d, uds_n_d, lds_n_d, vma_n_d, doe_d} = 5'b11110;
      rsp_valid_d = 1'b0;
      rsp_berr_d = 1'b0;
      pop = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge PI_CLK) begin
    if (!SYS_RESET_n) begin
      mclk_q <= '0;
      async_q <= '1;
      state_q <= IDLE;
      cur_q <= '0;
      second_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
      e_cnt_q <= '0;
      rdata_q <= '0;
      a_q <= '0;
      fc_q <= 3'b111;
      rw_q <= 1'b1;
      dout_q <= '0;
      doe_q <= 1'b0;
      {as_n_q, uds_n_q, lds_n_q, vma_n_q} <= 4'hF;
      rsp_valid_q <= 1'b0;
      rsp_berr_q <= 1'b0;
    end else begin
      mclk_q <= mclk_d;
      async_q <= async_d;
      state_q <= state_d;
      cur_q <= cur_d;
      second_q <= second_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
      e_cnt_q <= e_cnt_d;
      rdata_q <= rdata_d;
      a_q <= a_d;
      fc_q <= fc_d;
      rw_q <= rw_d;
      dout_q <= dout_d;
      doe_q <= doe_d;
      {as_n_q, uds_n_q, lds_n_q, vma_n_q} <= {as_n_d, uds_n_d, lds_n_d, vma_n_d};
      rsp_valid_q <= rsp_valid_d;
      rsp_berr_q <= rsp_berr_d;
    end
  end
  assign REQ_READY  = !full || pop;
  assign TXN_BUSY   = !empty || state_q != IDLE;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_BERR   = rsp_berr_q;
  assign RSP_RDATA  = rdata_q;
  assign M68K_A     = a_q;
  assign M68K_D_OUT = dout_q;
  assign M68K_D_OE  = doe_q;
  assign BUS_OE     = bgack_s;
  assign M68K_FC    = fc_q;
  assign M68K_AS_n  = as_n_q;
  assign M68K_UDS_n = uds_n_q;
  assign M68K_LDS_n = lds_n_q;
  assign M68K_RW    = rw_q;
  assign M68K_VMA_n = vma_n_q;
  assign M68K_E     = e_cnt_q >= EW'(E_HIGH_START);
endmodule

// File: tb/tb_m68k_bus_engine.sv
// tb_m68k_bus_engine: directed vectors with hand-computed expectations for the bus engine
module tb_m68k_bus_engine;
  logic PI_CLK = 0, SYS_RESET_n = 0, ABORT = 0, REQ_VALID = 0, REQ_READY, REQ_RW = 1;
  logic [23:0] REQ_ADDR = '0;
  logic [1:0] REQ_SIZE = '0;
  logic [2:0] REQ_FC = '0;
  logic [31:0] REQ_WDATA = '0;
  logic RSP_VALID, RSP_BERR, TXN_BUSY;
  logic [31:0] RSP_RDATA;
  logic M68K_CLK = 0;
  logic [22:0] M68K_A;
  logic [15:0] M68K_D_OUT, M68K_D_IN = '0;
  logic M68K_D_OE, BUS_OE, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n, M68K_E;
  logic [2:0] M68K_FC;
  logic M68K_DTACK_n = 1, M68K_BERR_n = 1, M68K_VPA_n = 1, M68K_BGACK_n = 1;
  m68k_bus_engine #(.TIMEOUT_CYCLES(16)) dut (
    .PI_CLK(PI_CLK), .SYS_RESET_n(SYS_RESET_n), .ABORT(ABORT),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_RW(REQ_RW),
    .REQ_SIZE(REQ_SIZE), .REQ_FC(REQ_FC), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_BERR(RSP_BERR), .RSP_RDATA(RSP_RDATA), .TXN_BUSY(TXN_BUSY),
    .M68K_CLK(M68K_CLK), .M68K_A(M68K_A), .M68K_D_OUT(M68K_D_OUT), .M68K_D_IN(M68K_D_IN),
    .M68K_D_OE(M68K_D_OE), .BUS_OE(BUS_OE), .M68K_FC(M68K_FC), .M68K_AS_n(M68K_AS_n),
    .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW), .M68K_VMA_n(M68K_VMA_n),
    .M68K_E(M68K_E), .M68K_DTACK_n(M68K_DTACK_n), .M68K_BERR_n(M68K_BERR_n),
    .M68K_VPA_n(M68K_VPA_n), .M68K_BGACK_n(M68K_BGACK_n)
  );
  initial forever #2 PI_CLK = ~PI_CLK;
  initial begin
    #1;
    forever #50 M68K_CLK = ~M68K_CLK;
  end
  int errors = 0, checks = 0;
  int fall_cnt = 0, as_cnt = 0, rsp_cnt = 0, as_fall_at = 0, rsp_fall_at = 0, vma_fall_at = 0;
  logic prev_as = 1, prev_vma = 1, rsp_berr_c = 0;
  logic [31:0] rsp_rdata_c = '0;
  logic [22:0] cap_a [16];
  logic [15:0] cap_d [16];
  logic [3:0] cap_ctl [16];
  logic [2:0] cap_fc [16];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge M68K_CLK) fall_cnt++;
  always @(negedge PI_CLK) begin
    if (prev_as && !M68K_AS_n) begin
      cap_a[as_cnt % 16] = M68K_A;
      cap_d[as_cnt % 16] = M68K_D_OUT;
      cap_ctl[as_cnt % 16] = {M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_OE};
      cap_fc[as_cnt % 16] = M68K_FC;
      as_cnt++;
      as_fall_at = fall_cnt;
    end
    if (prev_vma && !M68K_VMA_n) vma_fall_at = fall_cnt;
    if (RSP_VALID) begin
      rsp_cnt++;
      rsp_rdata_c = RSP_RDATA;
      rsp_berr_c = RSP_BERR;
      rsp_fall_at = fall_cnt;
    end
    prev_as = M68K_AS_n;
    prev_vma = M68K_VMA_n;
  end
  task automatic push(input logic [23:0] a, input logic rw, input logic [1:0] sz, input logic [2:0] fc, input logic [31:0] wd);
    REQ_ADDR = a;
    REQ_RW = rw;
    REQ_SIZE = sz;
    REQ_FC = fc;
    REQ_WDATA = wd;
    REQ_VALID = 1;
    @(negedge PI_CLK);
    REQ_VALID = 0;
  endtask
  task automatic wait_as(input logic v, input string tag);
    int n = 0;
    while (M68K_AS_n !== v && n < 4000) begin
      @(negedge PI_CLK);
      n++;
    end
    if (M68K_AS_n !== v) check(tag, M68K_AS_n, v);
    @(negedge PI_CLK);
  endtask
  task automatic wait_rsp(input int base, input string tag);
    int n = 0;
    while (rsp_cnt <= base && n < 4000) begin
      @(negedge PI_CLK);
      n++;
    end
    if (rsp_cnt <= base) check(tag, rsp_cnt, base + 1);
    @(negedge PI_CLK);
  endtask
  task automatic wait_e(input logic v, input string tag);
    int n = 0;
    while (M68K_E !== v && n < 4000) begin
      @(negedge PI_CLK);
      n++;
    end
    if (M68K_E !== v) check(tag, M68K_E, v);
  endtask
  task automatic bus_ack(input logic [15:0] d, input bit be, input string tag);
    M68K_D_IN = d;
    wait_as(1'b0, tag);
    @(negedge M68K_CLK);
    @(posedge M68K_CLK);
    if (be) M68K_BERR_n = 0;
    else M68K_DTACK_n = 0;
    wait_as(1'b1, tag);
    M68K_DTACK_n = 1;
    M68K_BERR_n = 1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int b, r, n, r1, f1, r2;
    repeat (5) @(negedge PI_CLK);
    check("rst_strobes", {M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_VMA_n}, 4'hF);
    check("rst_rw_fc", {M68K_RW, M68K_FC}, 4'hF);
    check("rst_doe_e", {M68K_D_OE, M68K_E}, 0);
    check("rst_rsp", {RSP_VALID, RSP_BERR}, 0);
    check("rst_rdata", RSP_RDATA, 0);
    SYS_RESET_n = 1;
    @(negedge PI_CLK);
    check("rst_ready", REQ_READY, 1);
    check("rst_busy", TXN_BUSY, 0);
    check("rst_bus_oe", BUS_OE, 1);
    wait_e(0, "e_lo0");
    wait_e(1, "e_rise1");
    r1 = fall_cnt;
    wait_e(0, "e_fall");
    f1 = fall_cnt;
    wait_e(1, "e_rise2");
    r2 = fall_cnt;
    check("e_high_len", f1 - r1, 4);
    check("e_period", r2 - r1, 10);
    b = as_cnt; r = rsp_cnt;
    push(24'hFF8800, 1, 2'd1, 3'd5, 0);
    bus_ack(16'hABCD, 0, "wr_ack");
    wait_rsp(r, "wr_rsp");
    check("wr_addr", cap_a[b % 16], 23'h7FC400);
    check("wr_ctl", cap_ctl[b % 16], 4'b0010);
    check("wr_fc", cap_fc[b % 16], 3'd5);
    check("wr_rdata", rsp_rdata_c, 32'h0000ABCD);
    check("wr_berr", rsp_berr_c, 0);
    b = as_cnt; r = rsp_cnt;
    push(24'h000400, 0, 2'd2, 3'd1, 32'h12345678);
    bus_ack(16'h0000, 0, "lw_ack1");
    bus_ack(16'h0000, 0, "lw_ack2");
    wait_rsp(r, "lw_rsp");
    repeat (60) @(negedge PI_CLK);
    check("lw_cycles", as_cnt - b, 2);
    check("lw_a0", cap_a[b % 16], 23'h000200);
    check("lw_d0", cap_d[b % 16], 16'h1234);
    check("lw_ctl0", cap_ctl[b % 16], 4'b0001);
    check("lw_a1", cap_a[(b + 1) % 16], 23'h000201);
    check("lw_d1", cap_d[(b + 1) % 16], 16'h5678);
    check("lw_rsps", rsp_cnt - r, 1);
    check("lw_berr", rsp_berr_c, 0);
    b = as_cnt; r = rsp_cnt;
    push(24'h000100, 1, 2'd2, 3'd5, 0);
    bus_ack(16'h1111, 0, "lr_ack1");
    bus_ack(16'h2222, 0, "lr_ack2");
    wait_rsp(r, "lr_rsp");
    check("lr_rdata", rsp_rdata_c, 32'h11112222);
    check("lr_cycles", as_cnt - b, 2);
    b = as_cnt; r = rsp_cnt;
    M68K_D_IN = 16'h5A3C;
    push(24'hFFFA01, 1, 2'd0, 3'd5, 0);
    wait_as(0, "vpa_as");
    M68K_VPA_n = 0;
    wait_rsp(r, "vpa_rsp");
    M68K_VPA_n = 1;
    check("vpa_ctl", cap_ctl[b % 16], 4'b1010);
    check("vpa_rdata", rsp_rdata_c, 32'h0000003C);
    check("vpa_berr", rsp_berr_c, 0);
    check("vpa_vma_seen", vma_fall_at > as_fall_at, 1);
    check("vpa_vma_to_end", rsp_fall_at - vma_fall_at, 7);
    check("vpa_vma_off", M68K_VMA_n, 1);
    r = rsp_cnt;
    push(24'h001000, 1, 2'd1, 3'd5, 0);
    wait_as(0, "to_as");
    wait_rsp(r, "to_rsp");
    check("to_berr", rsp_berr_c, 1);
    check("to_falls", rsp_fall_at - as_fall_at, 17);
    check("to_strobes", {M68K_AS_n, M68K_UDS_n, M68K_LDS_n}, 3'b111);
    b = as_cnt; r = rsp_cnt;
    push(24'h000100, 1, 2'd2, 3'd5, 0);
    bus_ack(16'h1111, 1, "lb_ack");
    wait_rsp(r, "lb_rsp");
    repeat (150) @(negedge PI_CLK);
    check("lb_cycles", as_cnt - b, 1);
    check("lb_rsps", rsp_cnt - r, 1);
    check("lb_berr", rsp_berr_c, 1);
    b = as_cnt; r = rsp_cnt;
    push(24'h000003, 1, 2'd1, 3'd5, 0);
    wait_rsp(r, "mis_rsp");
    check("mis_berr", rsp_berr_c, 1);
    check("mis_rdata", rsp_rdata_c, 0);
    r = rsp_cnt;
    push(24'h000004, 0, 2'd3, 3'd1, 0);
    wait_rsp(r, "rsv_rsp");
    check("rsv_berr", rsp_berr_c, 1);
    repeat (60) @(negedge PI_CLK);
    check("mis_no_as", as_cnt - b, 0);
    M68K_BGACK_n = 0;
    repeat (5) @(negedge PI_CLK);
    check("bg_bus_oe", BUS_OE, 0);
    b = as_cnt; r = rsp_cnt;
    for (int i = 0; i < 4; i++) push(24'h002000 + 24'(i * 2), 0, 2'd1, 3'd1, 32'hA000 + i);
    check("full_ready", REQ_READY, 0);
    check("full_busy", TXN_BUSY, 1);
    repeat (200) @(negedge PI_CLK);
    check("bg_block", as_cnt - b, 0);
    REQ_ADDR = 24'h002008;
    REQ_RW = 0;
    REQ_SIZE = 2'd1;
    REQ_VALID = 1;
    M68K_BGACK_n = 1;
    n = 0;
    while (!REQ_READY && n < 100) begin
      @(negedge PI_CLK);
      n++;
    end
    check("swap_ready", REQ_READY, 1);
    @(negedge PI_CLK);
    REQ_VALID = 0;
    check("swap_full", REQ_READY, 0);
    wait_as(0, "ab_as");
    ABORT = 1;
    @(negedge PI_CLK);
    ABORT = 0;
    check("ab_strobes", {M68K_AS_n, M68K_UDS_n, M68K_LDS_n}, 3'b111);
    check("ab_doe", M68K_D_OE, 0);
    check("ab_busy", TXN_BUSY, 0);
    check("ab_ready", REQ_READY, 1);
    repeat (300) @(negedge PI_CLK);
    check("ab_no_rsp", rsp_cnt - r, 0);
    check("ab_flushed", as_cnt - b, 1);
    r = rsp_cnt;
    push(24'h000010, 1, 2'd1, 3'd5, 0);
    bus_ack(16'h0F0F, 0, "post_ack");
    wait_rsp(r, "post_rsp");
    check("post_rdata", rsp_rdata_c, 32'h00000F0F);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
